// File: rtl/ex_muldiv_unit_if.sv
// EX-stage multiply/divide bundle: decode and operands in, stall and HI:LO result out.
// Latency: none, pure wiring between the EX segment and the engine.
// Backpressure: md_stall freezes ID/EX; pipe_stall holds a finished result in place.
interface ex_muldiv_unit_if;
  logic        refresh;
  logic        pipe_stall;
  logic        ex_mult;
  logic        ex_div;
  logic        ex_mdsign;
  logic [31:0] ex_A;
  logic [31:0] ex_B;
  logic        md_stall;
  logic        md_valid;
  logic [31:0] md_hi;
  logic [31:0] md_lo;

  modport master (
    output refresh, pipe_stall, ex_mult, ex_div, ex_mdsign, ex_A, ex_B,
    input  md_stall, md_valid, md_hi, md_lo
  );

  modport slave (
    input  refresh, pipe_stall, ex_mult, ex_div, ex_mdsign, ex_A, ex_B,
    output md_stall, md_valid, md_hi, md_lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative HI/LO multiply (shift-add) / divide (restoring) engine in EX.
// Latency: start + 32 BUSY + DONE; divide-by-zero may exit after 1 BUSY; MULDIV_FAST_MUL_EN gives a 1-cycle MULT.
// Backpressure: md_stall holds ID/EX until HI:LO is ready; pipe_stall parks the result in HOLD.
module ex_muldiv_unit #(
  parameter int WIDTH    = 32,    // only 32 is supported
  parameter bit DIV_ZERO = 1'b1   // 1: divide-by-zero leaves BUSY after one cycle
) (
  input logic              clk,
  input logic              reset,
  ex_muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, HOLD} state_t;

  state_t                 state, state_nxt;
  logic                   a_neg, b_neg, start, last, stall;
  logic [WIDTH-1:0]       mag_a, mag_b;
  logic                   op_div, neg_lo, neg_hi, b_zero;
  logic [WIDTH-1:0]       a_raw, opd, quo, rem, hi_reg, lo_reg;
  logic [2*WIDTH-1:0]     prod, mul_nxt, mul_fix, fast_prod;
  logic [CW-1:0]          cnt;
  logic [WIDTH:0]         mul_sum, div_shift, rem_nxt;
  logic [WIDTH+1:0]       div_diff;
  logic                   div_ok;
  logic [WIDTH-1:0]       quo_nxt, res_hi, res_lo;
  logic                   rem_top_unused;

  assign a_neg = bus.ex_mdsign & bus.ex_A[WIDTH-1];
  assign b_neg = bus.ex_mdsign & bus.ex_B[WIDTH-1];
  assign mag_a = a_neg ? -bus.ex_A : bus.ex_A;
  assign mag_b = b_neg ? -bus.ex_B : bus.ex_B;
  assign start = (bus.ex_mult | bus.ex_div) & ~bus.refresh;
  // A divide-by-zero result is fixed, so the loop can be cut short
  assign last  = (cnt == CW'(WIDTH - 1)) | (op_div & b_zero & DIV_ZERO);

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  assign fast_prod = (a_neg ^ b_neg) ? -(mag_a * mag_b) : (mag_a * mag_b);
`else
  localparam bit FAST_MUL = 1'b0;
  assign fast_prod = '0;
`endif

  // One shift-add / restoring-divide step plus the final sign fix-up
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opd} : '0);
    mul_nxt   = {mul_sum, prod[WIDTH-1:1]};
    mul_fix   = neg_lo ? -mul_nxt : mul_nxt;
    div_shift = {rem, quo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opd};
    div_ok    = ~div_diff[WIDTH+1];
    rem_nxt   = div_ok ? div_diff[WIDTH:0] : div_shift;
    quo_nxt   = {quo[WIDTH-2:0], div_ok};
    res_hi    = mul_fix[2*WIDTH-1:WIDTH];
    res_lo    = mul_fix[WIDTH-1:0];
    if (op_div) begin
      if (b_zero) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_lo = neg_lo ? -quo_nxt : quo_nxt;
        res_hi = neg_hi ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
      end
    end
  end

  // The partial remainder stays below the divisor, so its top bit is always zero
  assign rem_top_unused = rem_nxt[WIDTH];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and stall; refresh overrides everything, HOLD never restarts
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: if (start) begin
        stall     = 1'b1;
        state_nxt = (FAST_MUL && !bus.ex_div) ? DONE : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: state_nxt = bus.pipe_stall ? HOLD : IDLE;
      HOLD: if (!bus.pipe_stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.refresh) state_nxt = IDLE;
  end

  // Operand capture, iteration and result registers; refresh leaves HI/LO untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
      cnt    <= '0;
      op_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      b_zero <= 1'b0;
      a_raw  <= '0;
      opd    <= '0;
      quo    <= '0;
      rem    <= '0;
      prod   <= '0;
    end else if (!bus.refresh) begin
      case (state)
        IDLE: if (start) begin
          cnt    <= '0;
          op_div <= bus.ex_div;
          neg_lo <= a_neg ^ b_neg;
          neg_hi <= bus.ex_div ? a_neg : (a_neg ^ b_neg);
          b_zero <= (bus.ex_B == '0);
          a_raw  <= bus.ex_A;
          rem    <= '0;
          quo    <= mag_a;
          prod   <= {{WIDTH{1'b0}}, mag_b};
          opd    <= bus.ex_div ? mag_b : mag_a;
          if (FAST_MUL && !bus.ex_div) begin
            hi_reg <= fast_prod[2*WIDTH-1:WIDTH];
            lo_reg <= fast_prod[WIDTH-1:0];
          end
        end
        BUSY: begin
          cnt  <= cnt + 1'b1;
          prod <= mul_nxt;
          quo  <= quo_nxt;
          rem  <= rem_nxt[WIDTH-1:0];
          if (last) begin
            hi_reg <= res_hi;
            lo_reg <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.md_stall = stall;
  assign bus.md_valid = (state == DONE) || (state == HOLD);
  assign bus.md_hi    = hi_reg;
  assign bus.md_lo    = lo_reg;
endmodule
